// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pulls words from an upstream FIFO and sends them as UART frames
module fifo_uart_tx #(
  parameter int p_WORD_LEN     = 8,
  parameter int p_CLKS_PER_BIT = 16,
  parameter int p_PARITY_EN    = 0,
  parameter int p_STOP_BITS    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic [p_WORD_LEN-1:0] i_fifo_data,
  input  logic                  i_fifo_rdy,
  output logic                  o_fifo_deq,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done
);
  localparam int cw = $clog2(p_CLKS_PER_BIT);
  localparam int iw = (p_WORD_LEN > 2) ? $clog2(p_WORD_LEN) : 1;
  localparam logic [cw-1:0] last_cnt  = cw'(p_CLKS_PER_BIT - 1);
  localparam logic [iw-1:0] last_bit  = iw'(p_WORD_LEN - 1);
  localparam logic [iw-1:0] last_stop = iw'(p_STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;
  logic [cw-1:0] cnt, cnt_d;
  logic [iw-1:0] idx, idx_d;
  logic [p_WORD_LEN-1:0] shift, shift_d;
  logic tx_q, tx_d, tick, go;
  assign tick   = cnt == last_cnt;
  assign go     = i_reset_n && i_enable && i_fifo_rdy;
  assign o_tx   = tx_q;
  assign o_busy = state != IDLE;
  // next state, dequeue/done strobes, and the line level for the coming cycle
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    shift_d    = shift;
    o_fifo_deq = 1'b0;
    o_done     = 1'b0;
    cnt_d      = (state == IDLE || tick) ? '0 : cnt + 1'b1;
    case (state)
      IDLE: if (go) begin
        o_fifo_deq = 1'b1;
        shift_d    = i_fifo_data;
        state_d    = START;
      end
      START: if (tick) state_d = DATA;
      DATA: if (tick) begin
        idx_d = (idx == last_bit) ? '0 : idx + 1'b1;
        if (idx == last_bit) state_d = (p_PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_d = STOP;
      STOP: if (tick) begin
        idx_d = (idx == last_stop) ? '0 : idx + 1'b1;
        if (idx == last_stop) begin
          o_done  = 1'b1;
          state_d = IDLE;
          if (go) begin
            o_fifo_deq = 1'b1;
            shift_d    = i_fifo_data;
            state_d    = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = (state_d == START)  ? 1'b0 :
           (state_d == DATA)   ? shift_d[idx_d] :
           (state_d == PARITY) ? ^shift_d : 1'b1;
  end
  // state, counters, latched word and registered line output
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      tx_q  <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      shift <= shift_d;
      tx_q  <= tx_d;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed frame checks against a slot-level UART frame model
module tb_fifo_uart_tx;
  localparam int cpb = 4;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] data [3];
  logic rdy [3], deq [3], tx [3], busy [3], done [3];
  logic [7:0] mem [3][16];
  int head [3], tail [3];
  logic [7:0] mw [4];
  int mpar, mstop, mnf;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  // dut 0: no parity, 1 stop; dut 1: parity, 1 stop; dut 2: parity, 2 stops
  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign rdy[g]  = head[g] != tail[g];
    assign data[g] = mem[g][head[g][3:0]];
    fifo_uart_tx #(.p_WORD_LEN(8), .p_CLKS_PER_BIT(cpb), .p_PARITY_EN(g > 0 ? 1 : 0),
                   .p_STOP_BITS(g == 2 ? 2 : 1)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_fifo_data(data[g]),
      .i_fifo_rdy(rdy[g]), .o_fifo_deq(deq[g]), .o_tx(tx[g]), .o_busy(busy[g]), .o_done(done[g]));
  end

  // FIFO pop on each dequeue strobe
  always @(posedge clk) for (int k = 0; k < 3; k++) if (deq[k]) head[k] <= head[k] + 1;

  // expected line level t cycles after the first dequeue cycle (t=0)
  function automatic logic exp_tx(int t);
    int l, p, f;
    l = (9 + mpar + mstop) * cpb;
    if (t < 1 || t > l * mnf) return 1'b1;
    f = (t - 1) / l;
    p = ((t - 1) % l) / cpb;
    if (p == 0) return 1'b0;
    if (p <= 8) return mw[f][p-1];
    if (p == 9 && mpar == 1) return ^mw[f];
    return 1'b1;
  endfunction

  task automatic push(input int k, input logic [7:0] w);
    mem[k][tail[k][3:0]] = w;
    tail[k]++;
  endtask

  task automatic test_reset();
    push(0, 8'h81);
    en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (tx[k] !== 1'b1 || busy[k] !== 1'b0 || done[k] !== 1'b0 || deq[k] !== 1'b0) begin
          n_bad++;
          $display("FAIL reset dut%0d tx/busy/done/deq got=%b%b%b%b exp=1000", k, tx[k], busy[k], done[k], deq[k]);
        end
      end
    end
    en = 1'b0;
    tail[0] = head[0];
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_frames(input string name, input int k, input int n, input int drop);
    int l;
    logic e_busy, e_done, e_deq;
    mpar  = (k > 0) ? 1 : 0;
    mstop = (k == 2) ? 2 : 1;
    l = (9 + mpar + mstop) * cpb;
    mnf = (drop >= 0) ? 1 : n;
    for (int i = 0; i < n; i++) push(k, mw[i]);
    en = 1'b1;
    for (int t = 0; t <= l * mnf + 3; t++) begin
      @(negedge clk);
      e_busy = t >= 1 && t <= l * mnf;
      e_done = t >= 1 && t <= l * mnf && t % l == 0;
      e_deq  = t < l * mnf && t % l == 0;
      n_cmp += 4;
      if (tx[k] !== exp_tx(t)) begin
        n_bad++; $display("FAIL %s tx t=%0d got=%b exp=%b", name, t, tx[k], exp_tx(t));
      end
      if (busy[k] !== e_busy) begin
        n_bad++; $display("FAIL %s busy t=%0d got=%b exp=%b", name, t, busy[k], e_busy);
      end
      if (done[k] !== e_done) begin
        n_bad++; $display("FAIL %s done t=%0d got=%b exp=%b", name, t, done[k], e_done);
      end
      if (deq[k] !== e_deq) begin
        n_bad++; $display("FAIL %s deq t=%0d got=%b exp=%b", name, t, deq[k], e_deq);
      end
      @(posedge clk); #1;
      if (drop >= 0 && t + 1 >= drop) en = 1'b0;
    end
    en = 1'b0;
    tail[k] = head[k];
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    mw[0] = 8'hA5;
    test_frames("single", 0, 1, -1);
  endtask

  task automatic test_back_to_back();
    mw[0] = 8'h01; mw[1] = 8'hFF;
    test_frames("b2b", 0, 2, -1);
  endtask

  task automatic test_parity();
    mw[0] = 8'h07; test_frames("par07", 1, 1, -1);
    mw[0] = 8'h03; test_frames("par03", 1, 1, -1);
    mw[0] = 8'h07; mw[1] = 8'h03; test_frames("par_stop2", 2, 2, -1);
  endtask

  task automatic test_idle();
    en = 1'b1;
    for (int t = 0; t < 200; t++) begin
      if (t == 100) begin en = 1'b0; push(0, 8'h5A); end
      @(negedge clk);
      n_cmp++;
      if (deq[0] !== 1'b0 || tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
        n_bad++; $display("FAIL idle t=%0d deq/tx/busy got=%b%b%b exp=010", t, deq[0], tx[0], busy[0]);
      end
      @(posedge clk); #1;
    end
    tail[0] = head[0];
  endtask

  task automatic test_enable_drop();
    mw[0] = 8'h96; mw[1] = 8'h3C;
    test_frames("en_drop", 0, 2, 10);
  endtask

  task automatic test_mid_reset();
    push(0, 8'h5A);
    en = 1'b1;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      n_cmp++;
      if (deq[0] !== (t == 0)) begin
        n_bad++; $display("FAIL mrst_deq t=%0d got=%b exp=%b", t, deq[0], t == 0);
      end
      @(posedge clk); #1;
    end
    #2;
    n_cmp++;
    if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL mrst_pre busy got=%b exp=1", busy[0]); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++; $display("FAIL mrst_async tx/busy got=%b%b exp=10", tx[0], busy[0]);
    end
    push(0, 8'hC3);
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (deq[0] !== 1'b0 || done[0] !== 1'b0 || busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
        n_bad++; $display("FAIL mrst_hold deq/done/busy/tx got=%b%b%b%b exp=0001", deq[0], done[0], busy[0], tx[0]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (deq[0] !== 1'b1) begin n_bad++; $display("FAIL mrst_resume deq got=%b exp=1", deq[0]); end
    @(posedge clk); #1;
    en = 1'b0;
    mpar = 0; mstop = 1; mnf = 1; mw[0] = 8'hC3;
    for (int t = 1; t <= 43; t++) begin
      @(negedge clk);
      n_cmp += 2;
      if (tx[0] !== exp_tx(t)) begin n_bad++; $display("FAIL mrst_frame tx t=%0d got=%b exp=%b", t, tx[0], exp_tx(t)); end
      if (done[0] !== (t == 40)) begin n_bad++; $display("FAIL mrst_frame done t=%0d got=%b exp=%b", t, done[0], t == 40); end
      @(posedge clk); #1;
    end
    tail[0] = head[0];
  endtask

  task automatic test_random();
    int k, n;
    for (int it = 0; it < 8; it++) begin
      k = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) mw[i] = 8'($urandom);
      test_frames("random", k, n, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_idle();
    test_enable_drop();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
